// File: rtl/handshake_monitor_array.sv
// handshake_monitor_array: per-channel ready/valid protocol monitor with sticky errors,
// saturating transfer/stall counters and first-error capture.
module handshake_monitor_array #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                                          CLK,
  input  logic                                          ASYNCRESET,
  input  logic                                          enable,
  input  logic                                          clear,
  input  logic [NUM_CH-1:0]                             ch_valid,
  input  logic [NUM_CH-1:0]                             ch_ready,
  input  logic [NUM_CH*DATA_W-1:0]                      ch_data,
  output logic [NUM_CH-1:0]                             err_valid_drop,
  output logic [NUM_CH-1:0]                             err_data_change,
  output logic [NUM_CH-1:0]                             err_timeout,
  output logic [NUM_CH*CNT_W-1:0]                       xfer_count,
  output logic [CNT_W-1:0]                              stall_count,
  output logic                                          any_err,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0]  first_err_ch,
  output logic [1:0]                                    first_err_code
);
  localparam int FCW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int WW  = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, PEND} state_t;
  state_t            r_st   [NUM_CH];
  logic [WW-1:0]     r_wait [NUM_CH];
  logic [DATA_W-1:0] r_cap  [NUM_CH];
  logic [CNT_W-1:0]  r_xfer [NUM_CH];
  logic [NUM_CH-1:0] r_vd, r_dc, r_to, w_vd, w_dc, w_to, w_fire, w_stall;
  logic [FCW-1:0]    w_fch;
  logic [1:0]        w_fcode;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W-1:0] w_d;
    assign w_d        = ch_data[i*DATA_W +: DATA_W];
    assign w_fire[i]  = ch_valid[i] & ch_ready[i];
    assign w_stall[i] = ch_valid[i] & ~ch_ready[i];
    assign w_vd[i]    = (r_st[i] == PEND) & ~ch_valid[i];
    assign w_dc[i]    = (r_st[i] == PEND) & ch_valid[i] & (w_d != r_cap[i]);
    assign w_to[i]    = (r_st[i] == PEND) & w_stall[i] & (r_wait[i] == WW'(TIMEOUT - 1));
    assign xfer_count[i*CNT_W +: CNT_W] = r_xfer[i];
    always_ff @(posedge CLK or posedge ASYNCRESET)
      if (ASYNCRESET) begin
        r_st[i] <= IDLE;
        r_wait[i] <= '0;
        r_cap[i] <= '0;
        r_xfer[i] <= '0;
        {r_vd[i], r_dc[i], r_to[i]} <= '0;
      end else if (clear) begin
        r_st[i] <= IDLE;
        r_wait[i] <= '0;
        r_cap[i] <= '0;
        r_xfer[i] <= '0;
        {r_vd[i], r_dc[i], r_to[i]} <= '0;
      end else if (!enable) begin
        r_st[i] <= IDLE;
        r_wait[i] <= '0;
      end else begin
        r_vd[i] <= r_vd[i] | w_vd[i];
        r_dc[i] <= r_dc[i] | w_dc[i];
        r_to[i] <= r_to[i] | w_to[i];
        if (w_fire[i] && r_xfer[i] != '1) r_xfer[i] <= r_xfer[i] + 1'b1;
        if (r_st[i] == IDLE && w_stall[i]) begin
          r_st[i] <= PEND;
          r_cap[i] <= w_d;
          r_wait[i] <= WW'(1);
        end else if (r_st[i] == PEND) begin
          if (!w_stall[i]) begin
            r_st[i] <= IDLE;
            r_wait[i] <= '0;
          end else if (r_wait[i] != WW'(TIMEOUT)) r_wait[i] <= r_wait[i] + 1'b1;
        end
      end
  end
  // Scan high to low so the lowest channel index wins; within a channel the lowest code wins.
  always_comb begin
    w_fch = '0;
    w_fcode = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (w_vd[k] | w_dc[k] | w_to[k]) begin
        w_fch = FCW'(k);
        w_fcode = w_vd[k] ? 2'd1 : w_dc[k] ? 2'd2 : 2'd3;
      end
  end
  always_ff @(posedge CLK or posedge ASYNCRESET)
    if (ASYNCRESET) begin
      stall_count <= '0;
      any_err <= 1'b0;
      first_err_ch <= '0;
      first_err_code <= '0;
    end else if (clear) begin
      stall_count <= '0;
      any_err <= 1'b0;
      first_err_ch <= '0;
      first_err_code <= '0;
    end else if (enable) begin
      if (|w_stall && stall_count != '1) stall_count <= stall_count + 1'b1;
      any_err <= |{r_vd, r_dc, r_to, w_vd, w_dc, w_to};
      if (!any_err && |{w_vd, w_dc, w_to}) begin
        first_err_ch <= w_fch;
        first_err_code <= w_fcode;
      end
    end
  assign err_valid_drop  = r_vd;
  assign err_data_change = r_dc;
  assign err_timeout     = r_to;
endmodule

// File: tb/tb_handshake_monitor_array.sv
// tb_handshake_monitor_array: directed checks of handshake_monitor_array with hand-computed expectations.
module tb_handshake_monitor_array;
  logic        CLK = 0, ASYNCRESET = 1, enable = 1, clear = 0;
  logic [2:0]  ch_valid = 0, ch_ready = 0;
  logic [11:0] ch_data = 0;
  logic [2:0]  err_valid_drop, err_data_change, err_timeout;
  logic [47:0] xfer_count;
  logic [15:0] stall_count;
  logic        any_err;
  logic [1:0]  first_err_ch, first_err_code;
  logic [2:0]  s_vd, s_dc, s_to;
  logic [11:0] s_xfer;
  logic [3:0]  s_stall;
  logic        s_any;
  logic [1:0]  s_fch, s_fcode;
  int total = 0, bad = 0;

  handshake_monitor_array dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .enable(enable), .clear(clear),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
    .err_valid_drop(err_valid_drop), .err_data_change(err_data_change), .err_timeout(err_timeout),
    .xfer_count(xfer_count), .stall_count(stall_count), .any_err(any_err),
    .first_err_ch(first_err_ch), .first_err_code(first_err_code));

  handshake_monitor_array #(.CNT_W(4)) u_sat (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .enable(enable), .clear(clear),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
    .err_valid_drop(s_vd), .err_data_change(s_dc), .err_timeout(s_to),
    .xfer_count(s_xfer), .stall_count(s_stall), .any_err(s_any),
    .first_err_ch(s_fch), .first_err_code(s_fcode));

  always #5 CLK = ~CLK;

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [95:0] got, logic [95:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    ch_valid = 0;
    ch_ready = 0;
    ch_data = 0;
    clear = 1;
    cyc();
    clear = 0;
  endtask

  function automatic logic [95:0] all_out();
    return {err_valid_drop, err_data_change, err_timeout, xfer_count, stall_count, any_err,
            first_err_ch, first_err_code};
  endfunction

  initial begin
    #2;
    chk("reset_outputs", all_out(), 0);
    cyc();
    ASYNCRESET = 0;
    cyc();
    chk("idle_after_reset", all_out(), 0);
    // clean traffic on ch0
    ch_valid = 3'b001;
    ch_ready = 3'b001;
    for (int k = 1; k <= 5; k++) begin
      ch_data[3:0] = 4'(k);
      cyc();
    end
    ch_valid = 0;
    cyc();
    chk("t1_xfer0", xfer_count[15:0], 5);
    chk("t1_stall", stall_count, 0);
    chk("t1_any_err", any_err, 0);
    // stall then accept on ch1
    clr();
    ch_valid = 3'b010;
    ch_data[7:4] = 4'hA;
    cyc(3);
    chk("t2_xfer1_stalled", xfer_count[31:16], 0);
    ch_ready = 3'b010;
    cyc();
    ch_valid = 0;
    ch_ready = 0;
    cyc();
    chk("t2_xfer1", xfer_count[31:16], 1);
    chk("t2_stall", stall_count, 3);
    chk("t2_no_err", {err_valid_drop, err_data_change, err_timeout, any_err}, 0);
    // valid drop on ch2
    clr();
    ch_valid = 3'b100;
    cyc();
    chk("t3_no_err_yet", err_valid_drop, 0);
    ch_valid = 0;
    cyc();
    chk("t3_vdrop", err_valid_drop, 3'b100);
    chk("t3_first", {any_err, first_err_ch, first_err_code}, {1'b1, 2'd2, 2'd1});
    cyc(10);
    chk("t3_sticky", {err_valid_drop, any_err}, {3'b100, 1'b1});
    // simultaneous errors: ch0 data change and ch2 valid drop
    clr();
    ch_valid = 3'b101;
    ch_data = 12'h003;
    cyc();
    ch_valid = 3'b001;
    ch_data = 12'h004;
    cyc();
    chk("t4_dchange", err_data_change, 3'b001);
    chk("t4_vdrop", err_valid_drop, 3'b100);
    chk("t4_first", {first_err_ch, first_err_code}, {2'd0, 2'd2});
    // timeout on ch1
    clr();
    ch_valid = 3'b010;
    cyc(15);
    chk("t5_no_timeout_15", err_timeout, 0);
    cyc();
    chk("t5_timeout_16", err_timeout, 3'b010);
    cyc(4);
    ch_ready = 3'b010;
    cyc();
    ch_valid = 0;
    ch_ready = 0;
    cyc();
    chk("t5_xfer1", xfer_count[31:16], 1);
    chk("t5_stall", stall_count, 20);
    chk("t5_first", {first_err_ch, first_err_code}, {2'd1, 2'd3});
    // enable low mid-stall: counters hold, restart from IDLE without errors
    clr();
    ch_valid = 3'b001;
    ch_data = 12'h001;
    cyc(2);
    enable = 0;
    ch_data = 12'h002;
    cyc(3);
    chk("en_hold_stall", stall_count, 2);
    enable = 1;
    ch_data = 12'h007;
    cyc();
    chk("en_restart", {any_err, err_data_change, err_valid_drop, stall_count}, {1'b0, 3'b0, 3'b0, 16'd3});
    // clear while ch0 pending with an error event on the same edge
    ch_data = 12'h009;
    clear = 1;
    cyc();
    clear = 0;
    chk("t6_clear", all_out(), 0);
    // build up nonzero state, then async reset mid-stall
    ch_valid = 3'b100;
    ch_ready = 3'b100;
    cyc();
    ch_ready = 0;
    ch_valid = 3'b011;
    cyc();
    ch_valid = 3'b001;
    ch_data = 12'h00C;
    cyc();
    chk("t6_pre_reset", {any_err, err_valid_drop}, {1'b1, 3'b010});
    #2 ASYNCRESET = 1;
    #1 chk("t6_async_reset", all_out(), 0);
    #1 ASYNCRESET = 0;
    ch_data = 12'h00D;
    cyc(3);
    chk("t6_no_err_after_reset", {any_err, err_valid_drop, err_data_change}, 0);
    chk("t6_stall_after_reset", stall_count, 3);
    // saturation
    clr();
    ch_valid = 3'b001;
    ch_ready = 3'b001;
    cyc(20);
    ch_valid = 0;
    ch_ready = 0;
    cyc();
    chk("sat_cnt4", s_xfer[3:0], 15);
    chk("sat_cnt16", xfer_count[15:0], 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
